// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the dual-slot in-order issue scheduler.
package issue_scheduler_pkg;
  localparam int INS_PART_WID_DEF = 4;
  // Unit select is the MSB of the type field: 0 -> ALU, 1 -> MUL.
  localparam int UNIT_SEL_BIT = INS_PART_WID_DEF - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;
endpackage

// File: rtl/issue_scoreboard.sv
// Register busy bits: set on issue, cleared by up to two writebacks per cycle; set wins.
// Free lookup is combinational and treats a same-cycle writeback as already cleared.
module issue_scoreboard #(
  parameter int INS_PART_WID = 4,
  parameter int NUM_REGS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_a,
  input  logic [INS_PART_WID-1:0] set_a_reg,
  input  logic                    set_b,
  input  logic [INS_PART_WID-1:0] set_b_reg,
  input  logic                    clr_a,
  input  logic [INS_PART_WID-1:0] clr_a_reg,
  input  logic                    clr_b,
  input  logic [INS_PART_WID-1:0] clr_b_reg,
  output logic [NUM_REGS-1:0]     free,
  output logic                    all_clear
);
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_a) clr_mask[clr_a_reg] = 1'b1;
    if (clr_b) clr_mask[clr_b_reg] = 1'b1;
    if (set_a) set_mask[set_a_reg] = 1'b1;
    if (set_b) set_mask[set_b_reg] = 1'b1;
  end

  assign free      = ~busy | clr_mask;
  assign all_clear = (busy == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end
endmodule

// File: rtl/issue_scheduler.sv
// Dual-slot in-order issue to ALU/MUL: combinational fetch, packets 1 cycle later; stalls on hazards/unit not ready.
// ISSUE_SCHED_STATS_EN adds issue_count/stall_count outputs.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int INS_PART_WID = INS_PART_WID_DEF,
  parameter int NUM_REGS     = 2 ** INS_PART_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_1_valid,
  input  logic [INS_PART_WID-1:0] inst_type_1,
  input  logic [INS_PART_WID-1:0] inst_dest_1,
  input  logic [INS_PART_WID-1:0] inst_src0_1,
  input  logic [INS_PART_WID-1:0] inst_src1_1,
  input  logic                    inst_2_valid,
  input  logic [INS_PART_WID-1:0] inst_type_2,
  input  logic [INS_PART_WID-1:0] inst_dest_2,
  input  logic [INS_PART_WID-1:0] inst_src0_2,
  input  logic [INS_PART_WID-1:0] inst_src1_2,
  output logic                    inst_1_fetch,
  output logic                    inst_2_fetch,
  input  logic                    alu_ready,
  input  logic                    mul_ready,
  output logic                    alu_issue_valid,
  output logic [INS_PART_WID-1:0] alu_issue_type,
  output logic [INS_PART_WID-1:0] alu_issue_dest,
  output logic [INS_PART_WID-1:0] alu_issue_src0,
  output logic [INS_PART_WID-1:0] alu_issue_src1,
  output logic                    mul_issue_valid,
  output logic [INS_PART_WID-1:0] mul_issue_type,
  output logic [INS_PART_WID-1:0] mul_issue_dest,
  output logic [INS_PART_WID-1:0] mul_issue_src0,
  output logic [INS_PART_WID-1:0] mul_issue_src1,
  input  logic                    alu_wb_valid,
  input  logic [INS_PART_WID-1:0] alu_wb_dest,
  input  logic                    mul_wb_valid,
  input  logic [INS_PART_WID-1:0] mul_wb_dest,
  input  logic                    flush,
  output logic [1:0]              sched_state
`ifdef ISSUE_SCHED_STATS_EN
  , output logic [15:0]           issue_count
  , output logic [15:0]           stall_count
`endif
);
  localparam int SEL = UNIT_SEL_BIT + (INS_PART_WID - INS_PART_WID_DEF);
  localparam int PW  = 4 * INS_PART_WID;

  sched_state_e        state, state_nxt;
  logic [NUM_REGS-1:0] free;
  logic                all_clear;
  logic                unit1, unit2, rdy1, rdy2, can_issue, hz2, ok1, ok2;
  logic                alu_pick1, alu_pick2, mul_pick1, mul_pick2;
  logic [PW-1:0]       slot1_pkt, slot2_pkt, alu_pkt, mul_pkt;

  issue_scoreboard #(.INS_PART_WID(INS_PART_WID), .NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_a     (ok1),
    .set_a_reg (inst_dest_1),
    .set_b     (ok2),
    .set_b_reg (inst_dest_2),
    .clr_a     (alu_wb_valid),
    .clr_a_reg (alu_wb_dest),
    .clr_b     (mul_wb_valid),
    .clr_b_reg (mul_wb_dest),
    .free      (free),
    .all_clear (all_clear)
  );

  assign unit1     = inst_type_1[SEL];
  assign unit2     = inst_type_2[SEL];
  assign slot1_pkt = {inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1};
  assign slot2_pkt = {inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2};

  always_comb begin
    // A flush stops issue in the same cycle it is raised, not one cycle later.
    can_issue = !rst && (state != ST_DRAIN) && !flush;
    rdy1      = unit1 ? mul_ready : alu_ready;
    rdy2      = unit2 ? mul_ready : alu_ready;
    ok1       = can_issue && inst_1_valid && rdy1 &&
                free[inst_src0_1] && free[inst_src1_1] && free[inst_dest_1];
    hz2       = (inst_src0_2 == inst_dest_1) || (inst_src1_2 == inst_dest_1) ||
                (inst_dest_2 == inst_dest_1);
    ok2       = ok1 && inst_2_valid && (unit2 != unit1) && rdy2 && !hz2 &&
                free[inst_src0_2] && free[inst_src1_2] && free[inst_dest_2];
  end

  assign inst_1_fetch = ok1;
  assign inst_2_fetch = ok2;

  assign alu_pick1 = ok1 && !unit1;
  assign alu_pick2 = ok2 && !unit2;
  assign mul_pick1 = ok1 && unit1;
  assign mul_pick2 = ok2 && unit2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_issue_valid <= 1'b0;
      mul_issue_valid <= 1'b0;
      alu_pkt         <= '0;
      mul_pkt         <= '0;
    end else begin
      alu_issue_valid <= alu_pick1 || alu_pick2;
      mul_issue_valid <= mul_pick1 || mul_pick2;
      alu_pkt         <= alu_pick1 ? slot1_pkt : (alu_pick2 ? slot2_pkt : '0);
      mul_pkt         <= mul_pick1 ? slot1_pkt : (mul_pick2 ? slot2_pkt : '0);
    end
  end

  assign {alu_issue_type, alu_issue_dest, alu_issue_src0, alu_issue_src1} = alu_pkt;
  assign {mul_issue_type, mul_issue_dest, mul_issue_src0, mul_issue_src1} = mul_pkt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
                else if (inst_1_valid && !ok1) state_nxt = ST_STALL;
      ST_STALL: if (flush) state_nxt = ST_DRAIN;
                else if (ok1) state_nxt = ST_RUN;
      ST_DRAIN: if (!flush && all_clear) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign sched_state = state;

`ifdef ISSUE_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      issue_count <= issue_count + {15'd0, ok1} + {15'd0, ok2};
      if (state == ST_STALL) stall_count <= stall_count + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// Randomized and directed stimulus against a queue-based reference model with a decoupled packet monitor.
module tb_issue_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inst_1_valid, inst_2_valid;
  logic [3:0] inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1;
  logic [3:0] inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2;
  logic       inst_1_fetch, inst_2_fetch;
  logic       alu_ready, mul_ready;
  logic       alu_issue_valid, mul_issue_valid;
  logic [3:0] alu_issue_type, alu_issue_dest, alu_issue_src0, alu_issue_src1;
  logic [3:0] mul_issue_type, mul_issue_dest, mul_issue_src0, mul_issue_src1;
  logic       alu_wb_valid, mul_wb_valid;
  logic [3:0] alu_wb_dest, mul_wb_dest;
  logic       flush;
  logic [1:0] sched_state;
`ifdef ISSUE_SCHED_STATS_EN
  logic [15:0] issue_count, stall_count;
`endif

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .rst(rst),
    .inst_1_valid(inst_1_valid), .inst_type_1(inst_type_1), .inst_dest_1(inst_dest_1),
    .inst_src0_1(inst_src0_1), .inst_src1_1(inst_src1_1),
    .inst_2_valid(inst_2_valid), .inst_type_2(inst_type_2), .inst_dest_2(inst_dest_2),
    .inst_src0_2(inst_src0_2), .inst_src1_2(inst_src1_2),
    .inst_1_fetch(inst_1_fetch), .inst_2_fetch(inst_2_fetch),
    .alu_ready(alu_ready), .mul_ready(mul_ready),
    .alu_issue_valid(alu_issue_valid), .alu_issue_type(alu_issue_type),
    .alu_issue_dest(alu_issue_dest), .alu_issue_src0(alu_issue_src0), .alu_issue_src1(alu_issue_src1),
    .mul_issue_valid(mul_issue_valid), .mul_issue_type(mul_issue_type),
    .mul_issue_dest(mul_issue_dest), .mul_issue_src0(mul_issue_src0), .mul_issue_src1(mul_issue_src1),
    .alu_wb_valid(alu_wb_valid), .alu_wb_dest(alu_wb_dest),
    .mul_wb_valid(mul_wb_valid), .mul_wb_dest(mul_wb_dest),
    .flush(flush), .sched_state(sched_state)
`ifdef ISSUE_SCHED_STATS_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register busy table, scheduler mode, expected packet queues.
  bit          m_busy[16];
  int          m_state;
  logic [15:0] m_ic, m_sc;
  int          alu_q[$];
  int          mul_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit reg_free(input int r);
    return !m_busy[r] || (alu_wb_valid && int'(alu_wb_dest) == r) ||
           (mul_wb_valid && int'(mul_wb_dest) == r);
  endfunction

  task automatic evaluate();
    bit u1, u2, r1, r2, e1, e2, all_idle;
    if (rst) begin
      m_state = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_ic = '0;
      m_sc = '0;
      chk("rst_alu_pkt", int'({alu_issue_valid, alu_issue_type, alu_issue_dest, alu_issue_src0, alu_issue_src1}), 0);
      chk("rst_mul_pkt", int'({mul_issue_valid, mul_issue_type, mul_issue_dest, mul_issue_src0, mul_issue_src1}), 0);
    end
    chk("state", int'(sched_state), m_state);
`ifdef ISSUE_SCHED_STATS_EN
    chk("issue_count", int'(issue_count), int'(m_ic));
    chk("stall_count", int'(stall_count), int'(m_sc));
`endif
    u1 = inst_type_1[3];
    u2 = inst_type_2[3];
    r1 = u1 ? mul_ready : alu_ready;
    r2 = u2 ? mul_ready : alu_ready;
    e1 = !rst && m_state != 2 && !flush && inst_1_valid && r1 &&
         reg_free(inst_src0_1) && reg_free(inst_src1_1) && reg_free(inst_dest_1);
    e2 = e1 && inst_2_valid && (u1 != u2) && r2 &&
         reg_free(inst_src0_2) && reg_free(inst_src1_2) && reg_free(inst_dest_2) &&
         inst_src0_2 != inst_dest_1 && inst_src1_2 != inst_dest_1 && inst_dest_2 != inst_dest_1;
    chk("fetch1", int'(inst_1_fetch), int'(e1));
    chk("fetch2", int'(inst_2_fetch), int'(e2));
    if (rst) return;
    if (e1) begin
      if (u1) mul_q.push_back(int'({inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1}));
      else    alu_q.push_back(int'({inst_type_1, inst_dest_1, inst_src0_1, inst_src1_1}));
    end
    if (e2) begin
      if (u2) mul_q.push_back(int'({inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2}));
      else    alu_q.push_back(int'({inst_type_2, inst_dest_2, inst_src0_2, inst_src1_2}));
    end
    m_ic = m_ic + 16'(e1) + 16'(e2);
    if (m_state == 1) m_sc = m_sc + 16'd1;
    all_idle = 1;
    foreach (m_busy[i]) if (m_busy[i]) all_idle = 0;
    if (alu_wb_valid) m_busy[alu_wb_dest] = 0;
    if (mul_wb_valid) m_busy[mul_wb_dest] = 0;
    if (e1) m_busy[inst_dest_1] = 1;
    if (e2) m_busy[inst_dest_2] = 1;
    case (m_state)
      0: if (flush) m_state = 2; else if (inst_1_valid && !e1) m_state = 1;
      1: if (flush) m_state = 2; else if (e1) m_state = 0;
      default: if (!flush && all_idle) m_state = 0;
    endcase
  endtask

  // Packet monitor: each registered issue packet must match the next queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("alu_valid", int'(alu_issue_valid), int'(alu_q.size() != 0));
      if (alu_issue_valid && alu_q.size() != 0)
        chk("alu_pkt", int'({alu_issue_type, alu_issue_dest, alu_issue_src0, alu_issue_src1}), alu_q.pop_front());
      alu_q.delete();
      chk("mul_valid", int'(mul_issue_valid), int'(mul_q.size() != 0));
      if (mul_issue_valid && mul_q.size() != 0)
        chk("mul_pkt", int'({mul_issue_type, mul_issue_dest, mul_issue_src0, mul_issue_src1}), mul_q.pop_front());
      mul_q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    #1;
    evaluate();
    @(negedge clk);
  endtask

  task automatic slot1(input bit v, input int t, input int d, input int a, input int b);
    inst_1_valid = v; inst_type_1 = 4'(t); inst_dest_1 = 4'(d); inst_src0_1 = 4'(a); inst_src1_1 = 4'(b);
  endtask

  task automatic slot2(input bit v, input int t, input int d, input int a, input int b);
    inst_2_valid = v; inst_type_2 = 4'(t); inst_dest_2 = 4'(d); inst_src0_2 = 4'(a); inst_src1_2 = 4'(b);
  endtask

  task automatic idle();
    slot1(0, 0, 0, 0, 0);
    slot2(0, 0, 0, 0, 0);
    alu_ready = 1; mul_ready = 1;
    alu_wb_valid = 0; alu_wb_dest = 0;
    mul_wb_valid = 0; mul_wb_dest = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  function automatic logic [3:0] pick_wb();
    int bl[$];
    foreach (m_busy[i]) if (m_busy[i]) bl.push_back(i);
    if (bl.size() == 0) return 4'($urandom_range(15, 0));
    return 4'(bl[$urandom_range(bl.size() - 1, 0)]);
  endfunction

  initial begin
    idle();
    @(negedge clk);
    tick();
    rst = 0;

    // Dual issue to ALU and MUL, then a consumer of r3 stalls until writeback.
    slot1(1, 1, 3, 1, 2); slot2(1, 9, 4, 5, 6); tick();
    slot1(1, 0, 8, 3, 4); slot2(0, 0, 0, 0, 0); tick(); tick();
    alu_wb_valid = 1; alu_wb_dest = 3; mul_wb_valid = 1; mul_wb_dest = 4; tick();

    // Intra-pair RAW on r3: slot 2 waits for the ALU writeback.
    do_reset();
    slot1(1, 1, 3, 1, 2); slot2(1, 8, 5, 3, 6); tick();
    slot1(1, 8, 5, 3, 6); slot2(0, 0, 0, 0, 0); tick(); tick();
    alu_wb_valid = 1; alu_wb_dest = 3; tick();
    idle(); tick();

    // Structural: two ALU ops, then ALU not ready.
    do_reset();
    slot1(1, 2, 10, 11, 12); slot2(1, 3, 13, 14, 15); tick();
    slot1(1, 3, 13, 14, 15); slot2(0, 0, 0, 0, 0); alu_ready = 0; tick(); tick(); tick();
    alu_ready = 1; tick();
    idle(); tick();

    // Set wins over a same-cycle writeback to r7.
    do_reset();
    slot1(1, 0, 7, 1, 2); alu_wb_valid = 1; alu_wb_dest = 7; tick();
    alu_wb_valid = 0; slot1(1, 8, 9, 7, 1); tick(); tick();
    alu_wb_valid = 1; tick();
    idle(); tick();

    // Flush with r2 and r9 busy, drain, then resume.
    do_reset();
    slot1(1, 0, 2, 1, 3); slot2(1, 8, 9, 4, 5); tick();
    slot1(1, 1, 6, 1, 1); slot2(0, 0, 0, 0, 0); flush = 1; tick(); tick();
    alu_wb_valid = 1; alu_wb_dest = 2; tick();
    alu_wb_valid = 0; mul_wb_valid = 1; mul_wb_dest = 9; tick();
    mul_wb_valid = 0; tick();
    flush = 0; tick(); tick();
    idle(); tick();

    // Asynchronous reset asserted mid-cycle while stalled.
    do_reset();
    slot1(1, 0, 3, 1, 2); tick();
    slot1(1, 0, 4, 3, 3); tick(); tick();
    #2 rst = 1;
    tick();
    rst = 0; tick(); tick();
    idle(); tick();

    // Randomized traffic.
    do_reset();
    repeat (2000) begin
      slot1($urandom_range(3, 0) != 0, $urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom_range(15, 0));
      slot2($urandom_range(3, 0) != 0, $urandom_range(15, 0), $urandom_range(15, 0),
            $urandom_range(15, 0), $urandom_range(15, 0));
      alu_ready    = $urandom_range(3, 0) != 0;
      mul_ready    = $urandom_range(3, 0) != 0;
      alu_wb_valid = $urandom_range(1, 0) != 0;
      alu_wb_dest  = pick_wb();
      mul_wb_valid = $urandom_range(1, 0) != 0;
      mul_wb_dest  = pick_wb();
      flush        = $urandom_range(23, 0) == 0;
      rst          = $urandom_range(299, 0) == 0;
      tick();
    end
    rst = 0;
    idle();
    repeat (3) tick();
    chk("queues_drained", alu_q.size() + mul_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
